// File: rtl/aes_ctrl_burst_if.sv
// Handshake and strobe bundle between the AHB-side interface, the AES datapath and aes_ctrl_burst.
// The slave modport is the controller's view; master is the surrounding logic's view.
interface aes_ctrl_burst_if #(
    parameter int BLK_W = 16
);
    logic             start;
    logic             data_type;
    logic             enc_dec;
    logic [1:0]       key_len;
    logic [BLK_W-1:0] num_blocks;
    logic             word_valid;
    logic             out_ready;
    logic             chg_key_done;
    logic             enc_done;
    logic             opt_mode;
    logic             load_key;
    logic             preaddkey;
    logic             aes_load;
    logic             aes_enable;
    logic             ahb_mode;
    logic             ahb_shift_en;
    logic             done_chg_key;
    logic             burst_done;
    logic             busy;
    logic             error;
    logic [BLK_W-1:0] blk_left;

    modport slave (
        input  start, data_type, enc_dec, key_len, num_blocks,
        input  word_valid, out_ready, chg_key_done, enc_done,
        output opt_mode, load_key, preaddkey, aes_load, aes_enable, ahb_mode,
        output ahb_shift_en, done_chg_key, burst_done, busy, error, blk_left
    );

    modport master (
        output start, data_type, enc_dec, key_len, num_blocks,
        output word_valid, out_ready, chg_key_done, enc_done,
        input  opt_mode, load_key, preaddkey, aes_load, aes_enable, ahb_mode,
        input  ahb_shift_en, done_chg_key, burst_done, busy, error, blk_left
    );
endinterface

// File: rtl/aes_ctrl_burst.sv
// Burst-capable AES main controller: key load/expand, multi-block fetch/encrypt/write,
// per-word handshakes, watchdog on the datapath done signals and a sticky error state.
//
// state        | meaning
// S_IDLE       | waiting for start
// S_KEY_FETCH  | shifting in K key words
// S_KEY_EXPAND | GenKey expanding, watchdog running
// S_FETCH      | shifting in WORD_CNT data words
// S_PREADD     | initial AddRoundKey + block load strobe
// S_ENC        | AESctr start strobe
// S_WAIT       | waiting for enc_done, watchdog running
// S_WRITE      | shifting out WORD_CNT result words
// S_DONE       | burst complete pulse
// S_ERROR      | sticky error, left only by a new start
module aes_ctrl_burst #(
    parameter int WORD_CNT = 4,
    parameter int TIMEOUT  = 255,
    parameter int BLK_W    = 16
) (
    input logic             clk,
    input logic             rst,
    aes_ctrl_burst_if.slave bus
);
    localparam int WC_W = $clog2((WORD_CNT > 8) ? WORD_CNT : 8) + 1;
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_KEY_FETCH, S_KEY_EXPAND, S_FETCH, S_PREADD,
        S_ENC, S_WAIT, S_WRITE, S_DONE, S_ERROR
    } state_t;

    state_t           state_q, state_d;
    logic [WC_W-1:0]  word_cnt_q, word_cnt_d;
    logic [TO_W-1:0]  wd_cnt_q, wd_cnt_d;
    logic             key_valid_q, key_valid_d;
    logic             opt_mode_q, opt_mode_d;
    logic [1:0]       key_len_q, key_len_d;
    logic [BLK_W-1:0] blk_left_q, blk_left_d;
    logic             done_key_q, done_key_d;
    logic             shift_en;
    logic [WC_W-1:0]  key_words;
    logic             bad_start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            word_cnt_q  <= '0;
            wd_cnt_q    <= '0;
            key_valid_q <= 1'b0;
            opt_mode_q  <= 1'b0;
            key_len_q   <= 2'b00;
            blk_left_q  <= '0;
            done_key_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            wd_cnt_q    <= wd_cnt_d;
            key_valid_q <= key_valid_d;
            opt_mode_q  <= opt_mode_d;
            key_len_q   <= key_len_d;
            blk_left_q  <= blk_left_d;
            done_key_q  <= done_key_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        wd_cnt_d    = wd_cnt_q;
        key_valid_d = key_valid_q;
        opt_mode_d  = opt_mode_q;
        key_len_d   = key_len_q;
        blk_left_d  = blk_left_q;
        done_key_d  = 1'b0;
        shift_en    = 1'b0;

        case (key_len_q)
            2'b00:   key_words = WC_W'(4);
            2'b01:   key_words = WC_W'(6);
            default: key_words = WC_W'(8);
        endcase

        bad_start = (bus.key_len == 2'b11) ||
                    (!bus.data_type && (!key_valid_q || (bus.num_blocks == '0)));

        case (state_q)
            S_KEY_FETCH, S_FETCH: shift_en = bus.word_valid;
            S_WRITE:              shift_en = bus.out_ready;
            default:              shift_en = 1'b0;
        endcase

        if (shift_en) begin
            word_cnt_d = word_cnt_q + WC_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bad_start) begin
                        state_d = S_ERROR;
                    end else begin
                        opt_mode_d = bus.enc_dec;
                        key_len_d  = bus.key_len;
                        if (bus.data_type) begin
                            state_d     = S_KEY_FETCH;
                            key_valid_d = 1'b0;
                        end else begin
                            state_d    = S_FETCH;
                            blk_left_d = bus.num_blocks;
                        end
                    end
                end
            end
            S_KEY_FETCH: begin
                if (shift_en && (word_cnt_q == key_words - WC_W'(1))) begin
                    state_d = S_KEY_EXPAND;
                end
            end
            S_KEY_EXPAND: begin
                // A done arriving on the timeout cycle still counts as success.
                if (bus.chg_key_done) begin
                    state_d     = S_IDLE;
                    done_key_d  = 1'b1;
                    key_valid_d = 1'b1;
                end else if (wd_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    state_d = S_ERROR;
                end else begin
                    wd_cnt_d = wd_cnt_q + TO_W'(1);
                end
            end
            S_FETCH: begin
                if (shift_en && (word_cnt_q == WC_W'(WORD_CNT - 1))) begin
                    state_d = S_PREADD;
                end
            end
            S_PREADD: state_d = S_ENC;
            S_ENC:    state_d = S_WAIT;
            S_WAIT: begin
                if (bus.enc_done) begin
                    state_d = S_WRITE;
                end else if (wd_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    state_d = S_ERROR;
                end else begin
                    wd_cnt_d = wd_cnt_q + TO_W'(1);
                end
            end
            S_WRITE: begin
                if (shift_en && (word_cnt_q == WC_W'(WORD_CNT - 1))) begin
                    blk_left_d = blk_left_q - BLK_W'(1);
                    state_d    = (blk_left_q != BLK_W'(1)) ? S_FETCH : S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            S_ERROR: begin
                if (bus.start) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q) begin
            word_cnt_d = '0;
            wd_cnt_d   = '0;
        end
    end

    assign bus.opt_mode     = opt_mode_q;
    assign bus.load_key     = (state_q == S_KEY_EXPAND);
    assign bus.preaddkey    = (state_q == S_PREADD);
    assign bus.aes_load     = (state_q == S_PREADD);
    assign bus.aes_enable   = (state_q == S_ENC);
    assign bus.ahb_mode     = (state_q == S_WRITE);
    assign bus.ahb_shift_en = shift_en;
    assign bus.done_chg_key = done_key_q;
    assign bus.burst_done   = (state_q == S_DONE);
    assign bus.busy         = (state_q != S_IDLE) && (state_q != S_ERROR);
    assign bus.error        = (state_q == S_ERROR);
    assign bus.blk_left     = blk_left_q;
endmodule

// File: tb/tb_aes_ctrl_burst.sv
// Self-checking bench for aes_ctrl_burst: decision table, hand-written corner sequences and
// randomized transactions checked against an event-stream reference model.
module tb_aes_ctrl_burst;
    localparam int WORD_CNT = 4;
    localparam int TIMEOUT  = 255;
    localparam int BLK_W    = 16;

    localparam byte EV_IN  = "I";
    localparam byte EV_PRE = "P";
    localparam byte EV_ENC = "E";
    localparam byte EV_OUT = "O";
    localparam byte EV_KEY = "X";
    localparam byte EV_BD  = "B";
    localparam byte EV_KD  = "D";
    localparam byte EV_BAD = "?";

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_ctrl_burst_if #(.BLK_W(BLK_W)) bus ();

    aes_ctrl_burst #(.WORD_CNT(WORD_CNT), .TIMEOUT(TIMEOUT), .BLK_W(BLK_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit       dt;
        bit       ed;
        bit [1:0] kl;
        int       nb;
        bit       exp_err;
    } vec_t;

    int checks = 0;
    int errors = 0;

    byte              ev_q[$];
    byte              exp_q[$];
    logic [BLK_W-1:0] blk_q[$];

    int hs_mode   = 0;   // 0: valid/ready held high, 1: random, 2: word_valid toggles
    int enc_delay = 1;   // 0 withholds enc_done
    int key_delay = 1;   // 0 withholds chg_key_done
    int enc_cnt   = 0;
    int key_cnt   = 0;

    bit key_valid_m = 1'b0;
    bit exp_opt     = 1'b0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic logic [BLK_W+10:0] outs();
        return {bus.opt_mode, bus.load_key, bus.preaddkey, bus.aes_load, bus.aes_enable,
                bus.ahb_mode, bus.ahb_shift_en, bus.done_chg_key, bus.burst_done,
                bus.busy, bus.error, bus.blk_left};
    endfunction

    // Observed event stream, one entry per strobe per cycle
    always @(negedge clk) begin
        if (bus.ahb_shift_en && !bus.ahb_mode) ev_q.push_back(EV_IN);
        if (bus.preaddkey) begin
            ev_q.push_back(EV_PRE);
            blk_q.push_back(bus.blk_left);
        end
        if (bus.aes_load != bus.preaddkey) ev_q.push_back(EV_BAD);
        if (bus.aes_enable) ev_q.push_back(EV_ENC);
        if (bus.ahb_shift_en && bus.ahb_mode) ev_q.push_back(EV_OUT);
        if (bus.load_key) ev_q.push_back(EV_KEY);
        if (bus.burst_done) ev_q.push_back(EV_BD);
        if (bus.done_chg_key) ev_q.push_back(EV_KD);
    end

    // Datapath responders: done on the Nth cycle of WAIT / KEY_EXPAND
    always @(negedge clk) begin
        bus.enc_done = 1'b0;
        if (enc_cnt > 0) begin
            enc_cnt--;
            if (enc_cnt == 0) bus.enc_done = 1'b1;
        end
        if (bus.aes_enable && enc_delay > 0) enc_cnt = enc_delay;
        if (bus.load_key) key_cnt++;
        else key_cnt = 0;
        bus.chg_key_done = bus.load_key && (key_cnt == key_delay);
    end

    always @(posedge clk) begin
        #1;
        if (hs_mode == 0) begin
            bus.word_valid = 1'b1;
            bus.out_ready  = 1'b1;
        end else if (hs_mode == 1) begin
            bus.word_valid = 1'($urandom_range(0, 1));
            bus.out_ready  = 1'($urandom_range(0, 1));
        end else begin
            bus.word_valid = ~bus.word_valid;
            bus.out_ready  = 1'b1;
        end
    end

    function automatic int key_words(input bit [1:0] kl);
        return (kl == 2'b00) ? 4 : (kl == 2'b01) ? 6 : 8;
    endfunction

    function automatic bit start_err(input bit dt, input bit [1:0] kl, input int nb);
        return (kl == 2'b11) || (!dt && (!key_valid_m || nb == 0));
    endfunction

    function automatic void exp_data(input int nb);
        for (int b = 0; b < nb; b++) begin
            for (int w = 0; w < WORD_CNT; w++) exp_q.push_back(EV_IN);
            exp_q.push_back(EV_PRE);
            exp_q.push_back(EV_ENC);
            for (int w = 0; w < WORD_CNT; w++) exp_q.push_back(EV_OUT);
        end
        exp_q.push_back(EV_BD);
    endfunction

    function automatic void exp_key(input int k, input int d);
        for (int w = 0; w < k; w++) exp_q.push_back(EV_IN);
        for (int c = 0; c < d; c++) exp_q.push_back(EV_KEY);
        exp_q.push_back(EV_KD);
    endfunction

    task automatic cmp_seq(input string name);
        int bad;
        int m;
        bad = -1;
        chk({name, "_len"}, ev_q.size(), exp_q.size());
        m = (ev_q.size() < exp_q.size()) ? ev_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) if (ev_q[i] != exp_q[i] && bad < 0) bad = i;
        chk({name, "_first_bad_idx"}, bad, -1);
    endtask

    task automatic cmp_blk(input int nb);
        int bad;
        bad = -1;
        chk("blk_steps_len", blk_q.size(), nb);
        for (int b = 0; b < nb && b < blk_q.size(); b++)
            if (int'(blk_q[b]) != nb - b && bad < 0) bad = b;
        chk("blk_steps_first_bad", bad, -1);
    endtask

    task automatic do_start(input bit dt, input bit ed, input bit [1:0] kl, input int nb);
        @(posedge clk);
        #2;
        bus.start      = 1'b1;
        bus.data_type  = dt;
        bus.enc_dec    = ed;
        bus.key_len    = kl;
        bus.num_blocks = nb[BLK_W-1:0];
        @(posedge clk);
        #2;
        bus.start = 1'b0;
    endtask

    task automatic wait_end(output int n);
        bit done;
        done = 1'b0;
        n    = 0;
        while (!done && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
            if (bus.burst_done || bus.done_chg_key || bus.error) done = 1'b1;
        end
        if (!done) chk("end_wait_budget", n, -1);
    endtask

    task automatic run_txn(input bit dt, input bit ed, input bit [1:0] kl, input int nb,
                           input bit exp_err, output int n);
        ev_q.delete();
        blk_q.delete();
        exp_q.delete();
        n = 0;
        do_start(dt, ed, kl, nb);
        chk("start_error", bus.error, exp_err);
        chk("start_busy", bus.busy, !exp_err);
        if (exp_err) begin
            do_start(1'b0, !ed, 2'b00, 1);
            chk("clear_error", bus.error, 0);
            chk("clear_busy", bus.busy, 0);
            chk("error_no_strobes", ev_q.size(), 0);
            chk("opt_hold", bus.opt_mode, exp_opt);
        end else begin
            exp_opt = ed;
            if (dt) begin
                key_valid_m = 1'b0;
                exp_key(key_words(kl), key_delay);
            end else begin
                exp_data(nb);
            end
            wait_end(n);
            if (dt) begin
                cmp_seq("key_seq");
                key_valid_m = 1'b1;
            end else begin
                cmp_seq("burst_seq");
                cmp_blk(nb);
                chk("blk_left_end", bus.blk_left, 0);
            end
            chk("opt_mode", bus.opt_mode, exp_opt);
        end
    endtask

    initial begin
        vec_t tv[8];
        int   n;
        int   ocnt;
        bit   dt;
        bit [1:0] kl;
        int   nb;

        tv[0] = '{dt: 1'b0, ed: 1'b1, kl: 2'b11, nb: 1, exp_err: 1'b1};
        tv[1] = '{dt: 1'b0, ed: 1'b0, kl: 2'b00, nb: 0, exp_err: 1'b1};
        tv[2] = '{dt: 1'b1, ed: 1'b1, kl: 2'b11, nb: 0, exp_err: 1'b1};
        tv[3] = '{dt: 1'b0, ed: 1'b1, kl: 2'b00, nb: 2, exp_err: 1'b0};
        tv[4] = '{dt: 1'b1, ed: 1'b0, kl: 2'b01, nb: 0, exp_err: 1'b0};
        tv[5] = '{dt: 1'b0, ed: 1'b0, kl: 2'b10, nb: 1, exp_err: 1'b0};
        tv[6] = '{dt: 1'b1, ed: 1'b1, kl: 2'b00, nb: 0, exp_err: 1'b0};
        tv[7] = '{dt: 1'b0, ed: 1'b1, kl: 2'b01, nb: 2, exp_err: 1'b0};

        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.data_type  = 1'b0;
        bus.enc_dec    = 1'b0;
        bus.key_len    = 2'b00;
        bus.num_blocks = '0;
        bus.word_valid = 1'b0;
        bus.out_ready  = 1'b0;
        #22;
        chk("reset_outs", outs(), 0);
        @(negedge clk);
        rst = 1'b0;

        // Data before any key load
        run_txn(1'b0, 1'b0, 2'b00, 1, 1'b1, n);

        // Key load, 256-bit, chg_key_done on third expand cycle
        key_delay = 3;
        run_txn(1'b1, 1'b0, 2'b10, 0, 1'b0, n);
        chk("key_done_latency", n, 8 + 3 + 1);

        // Single block latency, no stalls
        enc_delay = 10;
        run_txn(1'b0, 1'b1, 2'b00, 1, 1'b0, n);
        chk("block_latency", n, WORD_CNT + 1 + 1 + 10 + WORD_CNT + 1);

        // Three-block burst
        run_txn(1'b0, 1'b0, 2'b00, 3, 1'b0, n);
        chk("burst3_latency", n, 3 * (WORD_CNT + 1 + 1 + 10 + WORD_CNT) + 1);

        // word_valid every other cycle
        hs_mode   = 2;
        enc_delay = 2;
        run_txn(1'b0, 1'b1, 2'b00, 1, 1'b0, n);
        hs_mode = 0;

        // start while busy is ignored
        ev_q.delete();
        blk_q.delete();
        exp_q.delete();
        exp_data(1);
        do_start(1'b0, 1'b0, 2'b00, 1);
        exp_opt = 1'b0;
        do_start(1'b1, 1'b1, 2'b11, 5);
        wait_end(n);
        cmp_seq("ignored_start_seq");
        chk("ignored_start_opt", bus.opt_mode, 0);

        // Watchdog: enc_done withheld
        enc_delay = 0;
        do_start(1'b0, 1'b0, 2'b00, 1);
        n = 0;
        while (!bus.aes_enable && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("reach_enc", bus.aes_enable, 1);
        n = 0;
        while (!bus.error && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("wait_to_error_cycles", n, TIMEOUT + 1);
        chk("error_outs", outs(), (longint'(1) << BLK_W) | 1);
        do_start(1'b0, 1'b1, 2'b00, 1);
        chk("error_cleared", bus.error, 0);
        chk("error_clear_idle", bus.busy, 0);

        // enc_done on the last allowed cycle wins over the timeout
        enc_delay = TIMEOUT;
        run_txn(1'b0, 1'b0, 2'b00, 1, 1'b0, n);

        // Decision table under random handshakes
        hs_mode   = 1;
        enc_delay = 5;
        key_delay = 4;
        for (int i = 0; i < 8; i++)
            run_txn(tv[i].dt, tv[i].ed, tv[i].kl, tv[i].nb, tv[i].exp_err, n);

        // Randomized transactions against the model
        for (int i = 0; i < 14; i++) begin
            dt        = ($urandom_range(0, 3) == 0);
            kl        = 2'($urandom_range(0, 3));
            nb        = $urandom_range(0, 3);
            enc_delay = $urandom_range(1, 20);
            key_delay = $urandom_range(1, 8);
            run_txn(dt, 1'($urandom_range(0, 1)), kl, nb, start_err(dt, kl, nb), n);
        end

        // Reset in the middle of block 2 write-back
        hs_mode   = 0;
        enc_delay = 3;
        ev_q.delete();
        do_start(1'b0, 1'b1, 2'b01, 3);
        ocnt = 0;
        n    = 0;
        while (ocnt < WORD_CNT + 2 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
            ocnt = 0;
            foreach (ev_q[j]) if (ev_q[j] == EV_OUT) ocnt++;
        end
        chk("reached_block2_write", ocnt, WORD_CNT + 2);
        chk("mid_write_mode", bus.ahb_mode, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_outs", outs(), 0);
        @(posedge clk);
        @(negedge clk);
        rst         = 1'b0;
        key_valid_m = 1'b0;
        exp_opt     = 1'b0;
        chk("post_reset_outs", outs(), 0);
        run_txn(1'b0, 1'b0, 2'b11, 1, 1'b1, n);
        run_txn(1'b0, 1'b0, 2'b00, 1, start_err(1'b0, 2'b00, 1), n);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/aes_ctrl_burst.md
# aes_ctrl_burst

Parametrised main controller for the AES accelerator, sitting between the AHB-lite slave interface and the GenKey / AESctr datapath. It generalises the single-block controller with several additions: configurable words per block, selectable key length (128/192/256), multi-block bursts, per-word valid/ready handshakes, a key-valid guard, a watchdog timeout and a sticky error state.

## Interface
Parameters:
- WORD_CNT, 4, 32-bit words per AES block shifted in or out
- TIMEOUT, 255, maximum cycles to wait for chg_key_done or enc_done before ERROR
- BLK_W, 16, width of the burst block counter

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request from the interface
- data_type  in  1  1 = key load, 0 = data; sampled with start
- enc_dec  in  1  0 = encrypt, 1 = decrypt; sampled with start
- key_len  in  2  00 = 128 (4 words), 01 = 192 (6), 10 = 256 (8), 11 = illegal; sampled with start
- num_blocks  in  BLK_W  burst length in blocks; sampled with start
- word_valid  in  1  interface holds an input word
- out_ready  in  1  interface can accept an output word
- chg_key_done  in  1  GenKey finished expansion
- enc_done  in  1  AESctr finished current block
- opt_mode  out  1  latched enc_dec
- load_key  out  1  GenKey load/expand request
- preaddkey  out  1  initial AddRoundKey strobe
- aes_load  out  1  load block into AESctr
- aes_enable  out  1  start AESctr
- ahb_mode  out  1  0 = interface shifts in, 1 = shifts out
- ahb_shift_en  out  1  shift one word this cycle
- done_chg_key  out  1  key stored pulse
- burst_done  out  1  burst complete pulse
- busy  out  1  state != IDLE and != ERROR
- error  out  1  high in ERROR
- blk_left  out  BLK_W  blocks remaining in current burst

## Operation
- IDLE:
  - start with key_len = 11 → ERROR.
  - start with data_type = 0 and key_valid = 0, or with data_type = 0 and num_blocks = 0 → ERROR.
  - start with data_type = 1 → KEY_FETCH; key_valid is cleared.
  - start with data_type = 0 (and no error condition) → FETCH; blk_left ← num_blocks.
  - opt_mode and key_len are latched on any accepted start.
- KEY_FETCH:
  - ahb_mode = 0 and ahb_shift_en = word_valid.
  - The word counter increments per accepted word.
  - After the Kth accepted word (K = 4/6/8 per key_len) → KEY_EXPAND.
- KEY_EXPAND:
  - load_key = 1 while in this state.
  - On chg_key_done: → IDLE, done_chg_key pulses 1 cycle, key_valid ← 1.
- FETCH: ahb_mode = 0, ahb_shift_en = word_valid; after WORD_CNT accepted words → PREADD.
- PREADD: preaddkey = 1 and aes_load = 1 for one cycle → ENC.
- ENC: aes_enable = 1 for one cycle → WAIT.
- WAIT: on enc_done → WRITE.
- WRITE:
  - ahb_mode = 1, ahb_shift_en = out_ready.
  - After WORD_CNT words, blk_left decrements.
  - If the new blk_left ≠ 0 → FETCH; otherwise → DONE.
- DONE: burst_done = 1 for one cycle → IDLE.
- ERROR:
  - error = 1, and all strobes are 0.
  - start → IDLE; key_valid is preserved and the request is not executed.
- Watchdog:
  - The counter clears on entry to KEY_EXPAND or WAIT and increments each cycle in those states.
  - Reaching TIMEOUT → ERROR.
  - If enc_done or chg_key_done arrives in the same cycle as the timeout, the done event wins.
- start is ignored in all states except IDLE and ERROR.
- The word counter clears on every state entry.

## Timing
- Reset values: state = IDLE; every output = 0; key_valid = 0; blk_left = 0; all counters = 0.
- Reset mid-operation:
  - rst asserted → outputs are 0 immediately (asynchronous).
  - Burst progress and key_valid are lost.
- Output decoding:
  - All outputs are decoded from the registered state, except ahb_shift_en, which is state AND (word_valid or out_ready).
  - opt_mode and blk_left are registers.
- Data-block latency, no stalls and enc_done after E cycles in WAIT: start → first FETCH shift is 1 cycle; FETCH takes WORD_CNT cycles; PREADD 1; ENC 1; WAIT E; WRITE WORD_CNT; DONE 1.
- Key path, no stalls: start → done_chg_key pulse = 1 + K + (cycles until chg_key_done) + 1.
- Deasserting valid/ready stalls the word counter with no loss.
- A word is accepted only in a cycle where ahb_shift_en = 1.
- blk_left updates on the clock edge after the last WRITE word.

## Test plan
- Key load, key_len = 10, word_valid held high, chg_key_done after 3 cycles → exactly 8 ahb_shift_en cycles, load_key high 3 cycles, done_chg_key single pulse, key_valid = 1.
- Data start before any key load → ERROR with error = 1; then start → IDLE with busy = 0.
- Burst, num_blocks = 3, WORD_CNT = 4, enc_done after 10 cycles → 3 × (4 in-shifts, preaddkey/aes_load pulse, aes_enable pulse, 4 out-shifts); blk_left steps 3→2→1→0; one burst_done.
- word_valid toggled every other cycle in FETCH → exactly 4 accepted words; PREADD only after the 4th.
- enc_done withheld, TIMEOUT = 255 → ERROR exactly 255 cycles after WAIT entry. Repeat with enc_done on cycle 255 → WRITE, not ERROR.
- rst asserted mid-WRITE of block 2 → all outputs 0 asynchronously, IDLE after release, key_valid = 0; then key_len = 11 start → ERROR.
